pc_redirect_ctrl: RTL and testbench

//  Fetch-side consumer of the branch-taken select: owns the program counter and applies
//  EX-stage branch/jump redirects. Squashes wrong-path instructions in IF/ID and ID/EX.
//  If a redirect arrives while the hazard unit stalls fetch, it is held pending until the

---
 rtl/cpu_pkg.sv | 18 +
 rtl/pc_redirect_ctrl_sat_counter.sv | 37 +++
 rtl/pc_redirect_ctrl.sv | 119 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared fetch-side constants and PC-control state encoding.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at its all-ones value instead of wrapping.
// Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_ctrl
// Brief   : Owns the fetch PC and applies EX-stage redirects, deferring them
//           across fetch stalls and squashing wrong-path IF/ID and ID/EX slots.
// Revision: 1.0
// ============================================================================
module pc_redirect_ctrl #(
    parameter int unsigned          ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(cpu_pkg::RESET_PC),
    parameter int unsigned          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_take_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              fetch_valid_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  redir_cnt_o
);

    import cpu_pkg::*;

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] tgt_aligned;
    logic [ADDR_W-1:0] pc_next_seq;
    logic              redirect_apply;

    assign tgt_aligned = {br_target_i[ADDR_W-1:2], 2'b00};
    assign pc_next_seq = pc_q + ADDR_W'(INSTR_BYTES);

    always_comb begin
        state_d        = ST_BOOT;
        pc_d           = pc_q;
        pend_tgt_d     = pend_tgt_q;
        misalign_d     = misalign_q;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        fetch_valid_o  = 1'b0;
        redirect_apply = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d       = ST_RUN;
                fetch_valid_o = 1'b1;
                if (br_take_i) begin
                    misalign_d    = misalign_q | (br_target_i[1:0] != 2'b00);
                    flush_id_ex_o = 1'b1;
                    if (stall_i) begin
                        // IF/ID is frozen by the stall; only the EX-bound slot can be killed now
                        pend_tgt_d = tgt_aligned;
                        state_d    = ST_PEND;
                    end else begin
                        pc_d           = tgt_aligned;
                        flush_if_id_o  = 1'b1;
                        redirect_apply = 1'b1;
                    end
                end else if (!stall_i) begin
                    pc_d = pc_next_seq;
                end
            end
            ST_PEND: begin
                state_d       = ST_PEND;
                fetch_valid_o = 1'b1;
                if (!stall_i) begin
                    pc_d           = pend_tgt_q;
                    flush_if_id_o  = 1'b1;
                    flush_id_ex_o  = 1'b1;
                    redirect_apply = 1'b1;
                    state_d        = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            misalign_q <= misalign_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redir_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect_apply),
        .cnt (redir_cnt_o)
    );

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_next_seq;
    assign misalign_o = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_redirect_ctrl
// Brief   : Directed plus random bench for pc_redirect_ctrl against a
//           behavioural fetch-PC model.
// Revision: 1.0
// ============================================================================
module tb_pc_redirect_ctrl;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_i;
    logic              br_take_i;
    logic [ADDR_W-1:0] br_target_i;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_plus4_o;
    logic              fetch_valid_o;
    logic              flush_if_id_o;
    logic              flush_id_ex_o;
    logic              misalign_o;
    logic [CNT_W-1:0]  redir_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch address, whether we are still booting, whether a
    // redirect is waiting for the stall to drop, and its target.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_pend;
    logic [31:0] m_ptgt;
    bit          m_mis;
    int          m_cnt;

    pc_redirect_ctrl #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .br_take_i     (br_take_i),
        .br_target_i   (br_target_i),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .fetch_valid_o (fetch_valid_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .misalign_o    (misalign_o),
        .redir_cnt_o   (redir_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_boot = 1'b1;
        m_pend = 1'b0;
        m_ptgt = '0;
        m_mis  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic check_outputs(input string tag);
        bit exp_fif;
        bit exp_fex;
        exp_fif = !m_boot && ((m_pend && !stall_i) || (!m_pend && br_take_i && !stall_i));
        exp_fex = !m_boot && ((m_pend && !stall_i) || (!m_pend && br_take_i));
        check({tag, ".pc"},       pc_o,                 m_pc);
        check({tag, ".pc4"},      pc_plus4_o,           m_pc + 32'd4);
        check({tag, ".valid"},    32'(fetch_valid_o),   32'(!m_boot));
        check({tag, ".fif"},      32'(flush_if_id_o),   32'(exp_fif));
        check({tag, ".fex"},      32'(flush_id_ex_o),   32'(exp_fex));
        check({tag, ".mis"},      32'(misalign_o),      32'(m_mis));
        check({tag, ".cnt"},      32'(redir_cnt_o),     32'(m_cnt));
    endtask

    task automatic model_advance(input bit r, input bit s, input bit t, input logic [31:0] tgt);
        if (r) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_pend) begin
            if (!s) begin
                m_pc   = m_ptgt;
                m_pend = 1'b0;
                if (m_cnt < 3) m_cnt++;
            end
        end else if (t) begin
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            if (s) begin
                m_ptgt = tgt & 32'hFFFF_FFFC;
                m_pend = 1'b1;
            end else begin
                m_pc = tgt & 32'hFFFF_FFFC;
                if (m_cnt < 3) m_cnt++;
            end
        end else if (!s) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    // One cycle: drive, check mid-cycle against the model, clock, then advance model.
    task automatic step(input string tag, input bit r, input bit s, input bit t,
                        input logic [31:0] tgt);
        rst         = r;
        stall_i     = s;
        br_take_i   = t;
        br_target_i = tgt;
        #2;
        check_outputs(tag);
        @(posedge clk);
        #1;
        model_advance(r, s, t, tgt);
    endtask

    initial begin
        rst         = 1'b1;
        stall_i     = 1'b0;
        br_take_i   = 1'b0;
        br_target_i = '0;
        @(posedge clk);
        #1;
        model_reset();

        // Free-run after reset
        step("t1_boot", 1'b0, 1'b0, 1'b0, 32'h0);
        check("t1_pc0", pc_o, 32'h0);
        step("t1_c0", 1'b0, 1'b0, 1'b0, 32'h0);
        step("t1_c1", 1'b0, 1'b0, 1'b0, 32'h0);
        step("t1_c2", 1'b0, 1'b0, 1'b0, 32'h0);
        check("t1_pc12", pc_o, 32'hC);
        step("t1_c3", 1'b0, 1'b0, 1'b0, 32'h0);
        check("t2_pc10", pc_o, 32'h10);

        // Unstalled redirect
        step("t2_br", 1'b0, 1'b0, 1'b1, 32'h100);
        check("t2_pc100", pc_o, 32'h100);
        check("t2_cnt1", 32'(redir_cnt_o), 32'd1);

        // Redirect under a 3-cycle stall
        step("t3_br", 1'b0, 1'b1, 1'b1, 32'h200);
        step("t3_s1", 1'b0, 1'b1, 1'b1, 32'h340);
        step("t3_s2", 1'b0, 1'b1, 1'b0, 32'h0);
        check("t3_hold", pc_o, 32'h100);
        step("t3_rel", 1'b0, 1'b0, 1'b1, 32'h480);
        check("t3_pc200", pc_o, 32'h200);

        // Misaligned target
        step("t4_br", 1'b0, 1'b0, 1'b1, 32'h203);
        check("t4_pc", pc_o, 32'h200);
        check("t4_mis", 32'(misalign_o), 32'd1);
        step("t4_run", 1'b0, 1'b0, 1'b0, 32'h0);

        // Wrap at top of address space and counter saturation
        step("t5_br", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("t5_wrap", 1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_pc0", pc_o, 32'h0);
        step("t5_br2", 1'b0, 1'b0, 1'b1, 32'h40);
        step("t5_br3", 1'b0, 1'b0, 1'b1, 32'h80);
        check("t5_sat", 32'(redir_cnt_o), 32'd3);

        // Reset while a redirect is pending
        step("t6_br", 1'b0, 1'b1, 1'b1, 32'h500);
        step("t6_rst", 1'b1, 1'b1, 1'b1, 32'h600);
        check("t6_pc", pc_o, RESET_PC);
        check("t6_cnt", 32'(redir_cnt_o), 32'd0);
        step("t6_boot", 1'b0, 1'b0, 1'b1, 32'h700);
        check("t6_mis", 32'(misalign_o), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit          r;
            bit          s;
            bit          t;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 35);
            t   = ($urandom_range(0, 99) < 30);
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            step("rnd", r, s, t, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
